// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared constants for the iterative divider.
// State codes, handshake levels and result bus width.
package div_unit_pkg;

  localparam logic [1:0] DivFree   = 2'b00;
  localparam logic [1:0] DivByZero = 2'b01;
  localparam logic [1:0] DivOn     = 2'b10;
  localparam logic [1:0] DivEnd    = 2'b11;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  localparam logic DivStart = 1'b1;
  localparam logic DivStop  = 1'b0;

  localparam int DoubleRegBus = 64;

endpackage

// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring divider, DIV/DIVU.
// One quotient bit per cycle; result is {remainder, quotient}.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEPS = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  localparam int CW = $clog2(STEPS + 1);
  localparam logic [CW-1:0] LAST = CW'(STEPS);

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH:0]   dividend;
  logic [WIDTH-1:0]   divisor;
  logic               sign1;
  logic               sign2;
  logic               sdiv;

  logic [WIDTH:0]     div_temp;
  logic [WIDTH-1:0]   op1_abs;
  logic [WIDTH-1:0]   op2_abs;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // trial subtraction of the divisor from the partial remainder
  assign div_temp = {1'b0, dividend[2*WIDTH-1:WIDTH]}
                  - {1'b0, divisor};

  // operand magnitudes, taken only for signed requests
  assign op1_abs = (signed_div_i && opdata1_i[WIDTH-1])
                 ? (~opdata1_i + 1'b1) : opdata1_i;
  assign op2_abs = (signed_div_i && opdata2_i[WIDTH-1])
                 ? (~opdata2_i + 1'b1) : opdata2_i;

  // unsigned result split and sign restoration
  assign quo = dividend[WIDTH-1:0];
  assign rem = dividend[2*WIDTH:WIDTH+1];
  assign quo_fix = (sdiv && (sign1 ^ sign2)) ? (~quo + 1'b1) : quo;
  assign rem_fix = (sdiv && sign1) ? (~rem + 1'b1) : rem;

  assign busy_o = (state == DivByZero) || (state == DivOn);

  // divider state machine and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= DivFree;
      cnt      <= '0;
      dividend <= '0;
      divisor  <= '0;
      sign1    <= 1'b0;
      sign2    <= 1'b0;
      sdiv     <= 1'b0;
      result_o <= '0;
      ready_o  <= DivResultNotReady;
    end else begin
      unique case (state)
        DivFree: begin
          if (start_i == DivStart && !annul_i) begin
            cnt <= '0;
            if (opdata2_i == '0) begin
              state <= DivByZero;
            end else begin
              state    <= DivOn;
              dividend <= {{WIDTH{1'b0}}, op1_abs, 1'b0};
              divisor  <= op2_abs;
              sign1    <= opdata1_i[WIDTH-1];
              sign2    <= opdata2_i[WIDTH-1];
              sdiv     <= signed_div_i;
            end
          end
        end
        DivByZero: begin
          // two cycles here so a zero divisor answers after k+2
          if (annul_i) begin
            state <= DivFree;
            cnt   <= '0;
          end else if (cnt == '0) begin
            cnt <= cnt + 1'b1;
          end else begin
            state    <= DivEnd;
            cnt      <= '0;
            dividend <= '0;
            result_o <= '0;
            ready_o  <= DivResultReady;
          end
        end
        DivOn: begin
          if (annul_i) begin
            state <= DivFree;
            cnt   <= '0;
          end else if (cnt != LAST) begin
            if (div_temp[WIDTH]) begin
              dividend <= {dividend[2*WIDTH-1:0], 1'b0};
            end else begin
              dividend <= {div_temp[WIDTH-1:0],
                           dividend[WIDTH-1:0], 1'b1};
            end
            cnt <= cnt + 1'b1;
          end else begin
            state    <= DivEnd;
            cnt      <= '0;
            result_o <= {rem_fix, quo_fix};
            ready_o  <= DivResultReady;
          end
        end
        DivEnd: begin
          if (start_i == DivStop) begin
            state    <= DivFree;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
          end
        end
        default: state <= DivFree;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed checks of div_unit.
// Expected values are hand-computed constants.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;

  int checks;
  int failures;

  div_unit #(.WIDTH(32), .STEPS(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .signed_div_i(signed_div_i),
    .opdata1_i   (opdata1_i),
    .opdata2_i   (opdata2_i),
    .start_i     (start_i),
    .annul_i     (annul_i),
    .result_o    (result_o),
    .ready_o     (ready_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic sd,
                       input logic [31:0] a,
                       input logic [31:0] b);
    signed_div_i = sd;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    tick();
  endtask

  task automatic wait_ready(input int lim, output int lat,
                            output int busy_n);
    lat    = -1;
    busy_n = 0;
    for (int n = 1; n <= lim; n++) begin
      tick();
      if (ready_o) begin
        lat = n;
        break;
      end
      if (busy_o) busy_n++;
    end
  endtask

  task automatic do_div(input string tag, input logic sd,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [63:0] exp,
                        input int exp_lat);
    int lat;
    int bn;
    issue(sd, a, b);
    wait_ready(exp_lat + 5, lat, bn);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_res"}, result_o, exp);
    start_i = 1'b0;
    tick();
    chk({tag, "_drop"}, {63'd0, ready_o}, 64'd0);
  endtask

  initial begin
    int lat;
    int bn;
    checks       = 0;
    failures     = 0;
    rst          = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;

    #2;
    chk("rst_res", result_o, 64'd0);
    chk("rst_rdy", {63'd0, ready_o}, 64'd0);
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    tick();
    tick();
    rst = 1'b1;

    // 100/7 with operand scramble, busy window, hold in END
    issue(1'b0, 32'd100, 32'd7);
    chk("u100_busy_k", {63'd0, busy_o}, 64'd1);
    opdata1_i    = 32'hDEAD_BEEF;
    opdata2_i    = 32'h0000_0003;
    signed_div_i = 1'b1;
    wait_ready(40, lat, bn);
    chk("u100_lat", 64'(lat), 64'd33);
    chk("u100_busy_n", 64'(bn), 64'd32);
    chk("u100_busy_end", {63'd0, busy_o}, 64'd0);
    chk("u100_res", result_o, 64'h00000002_0000000E);
    for (int i = 0; i < 3; i++) begin
      annul_i = (i == 1);
      tick();
      chk("hold_res", result_o, 64'h00000002_0000000E);
      chk("hold_rdy", {63'd0, ready_o}, 64'd1);
    end
    annul_i = 1'b0;
    start_i = 1'b0;
    tick();
    chk("drop_rdy", {63'd0, ready_o}, 64'd0);
    chk("drop_res", result_o, 64'd0);
    chk("drop_busy", {63'd0, busy_o}, 64'd0);

    do_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2,
           64'hFFFFFFFF_FFFFFFFD, 33);
    do_div("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE,
           64'h00000001_FFFFFFFD, 33);
    do_div("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
           64'h00000000_80000000, 33);
    do_div("s_0_m5", 1'b1, 32'd0, 32'hFFFF_FFFB,
           64'd0, 33);
    do_div("u_big", 1'b0, 32'hFFFF_FFFF, 32'd16,
           64'h0000000F_0FFFFFFF, 33);

    // zero divisor: not ready after k+1, ready after k+2
    issue(1'b0, 32'd5, 32'd0);
    chk("z_busy_k", {63'd0, busy_o}, 64'd1);
    tick();
    chk("z_rdy_k1", {63'd0, ready_o}, 64'd0);
    tick();
    chk("z_rdy_k2", {63'd0, ready_o}, 64'd1);
    chk("z_res", result_o, 64'd0);
    start_i = 1'b0;
    tick();

    // annul mid-operation
    issue(1'b0, 32'd100, 32'd7);
    for (int i = 0; i < 9; i++) tick();
    annul_i = 1'b1;
    start_i = 1'b0;
    tick();
    annul_i = 1'b0;
    chk("ann_busy", {63'd0, busy_o}, 64'd0);
    wait_ready(30, lat, bn);
    chk("ann_norise", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);
    do_div("u_9_3", 1'b0, 32'd9, 32'd3,
           64'h00000000_00000003, 33);

    // annul while free blocks acceptance
    annul_i = 1'b1;
    issue(1'b0, 32'd8, 32'd2);
    tick();
    chk("ann_free", {63'd0, busy_o}, 64'd0);
    start_i = 1'b0;
    annul_i = 1'b0;
    tick();

    // asynchronous reset between edges mid-operation
    issue(1'b0, 32'd100, 32'd7);
    for (int i = 0; i < 4; i++) tick();
    #3;
    rst = 1'b0;
    #1;
    chk("arst_busy", {63'd0, busy_o}, 64'd0);
    chk("arst_rdy", {63'd0, ready_o}, 64'd0);
    chk("arst_res", result_o, 64'd0);
    start_i = 1'b0;
    tick();
    rst = 1'b1;
    do_div("u100_post", 1'b0, 32'd100, 32'd7,
           64'h00000002_0000000E, 33);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
